pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Consumes the control unit's decoded flow/system signals (cu_Jump, cu_Branch, cu_hlt, cu_reset, cu_inSignal).
//  Produces the program counter that addresses instruction memory, so it closes the opcode fetch -> decode loop.
//  Sequences HALT, IN (wait for user confirm) and program reset.
//  Gates datapath side effects through instr_valid: regfile and data-memory writes qualify with it.
// PARAMETERS
//  PC_W     10  program counter / instruction address width
//  COUNT_W  32  width of retired-instruction counter
// PORTS
//  clock          in   1        single system clock, rising edge
//  reset          in   1        asynchronous, active-high; clears all state
//  cu_Jump        in   2        00 none, 01 absolute jump, 10 jump-to-register, 11 treated as 00
//  cu_Branch      in   1        current instruction is a conditional branch
//  branch_taken   in   1        ALU branch condition result for current instruction
//  cu_hlt         in   1        halt instruction
//  cu_reset       in   1        program-reset instruction
//  cu_inSignal    in   1        IN instruction, needs user confirm
//  in_confirm     in   1        user confirm button, already synchronised, level
//  resume         in   1        leave HALT, level, edge-detected internally
//  jump_target    in   PC_W     absolute target for cu_Jump=01
//  reg_target     in   PC_W     register value for cu_Jump=10
//  branch_target  in   PC_W     absolute branch target
//  pc             out  PC_W     current instruction address
//  link_addr      out  PC_W     pc+1 (mod 2^PC_W), for jump-and-link write data
//  instr_valid    out  1        current instruction may commit side effects this cycle
//  halted         out  1        state==HALT
//  waiting_in     out  1        state==WAIT_IN
//  retired        out  COUNT_W  count of cycles with instr_valid=1, saturating
// BEHAVIOUR
//  Reset values:
//   pc=0, state=RUN, retired=0.
//   Edge-detect registers for in_confirm/resume = 0.
//   Resulting outputs: instr_valid=1, halted=0, waiting_in=0, link_addr=1.
//  States: RUN, WAIT_IN, COMMIT_IN, HALT. Outputs decode from registered state.
//   instr_valid=1 in RUN and COMMIT_IN, 0 otherwise.
//  RUN next-pc priority, evaluated in if/else order; X on lower-priority inputs must not affect the result:
//   1 cu_reset             -> pc<=0, retired<=0, stay RUN
//   2 cu_hlt               -> pc held, ->HALT; instr_valid=1 for this cycle only (no side effects decoded)
//   3 cu_inSignal          -> pc held, ->WAIT_IN; instr_valid forced 0 in this cycle
//   4 cu_Jump=01           -> pc<=jump_target
//   5 cu_Jump=10           -> pc<=reg_target
//   6 cu_Branch&taken      -> pc<=branch_target
//   7 otherwise            -> pc<=pc+1
//  In RUN with cu_inSignal=1, instr_valid is combinationally 0 (the only combinational term).
//  WAIT_IN:
//   Leave only on in_confirm rising edge (in_confirm & ~prev), detected while in WAIT_IN.
//   A level already high on entry does not count; requires release and press.
//   On that edge -> COMMIT_IN.
//  COMMIT_IN:
//   One cycle, instr_valid=1 so the IN write commits exactly once.
//   pc<=pc+1, ->RUN. Other cu_* inputs are ignored here.
//  HALT:
//   pc held; cu_* ignored.
//   On resume rising edge: pc<=pc+1, ->RUN.
//  Edge-detect flops sample every cycle in all states.
//  pc+1 wraps from 2^PC_W-1 to 0; applies to link_addr as well.
//  retired increments every cycle with instr_valid=1 and saturates at all-ones.
//   cu_reset clears retired; the clearing cycle itself is not counted.
//  Async reset mid-WAIT_IN or mid-HALT: immediate return to reset values; no commit occurs.
// TESTING
//  T1 reset, 4 cycles of plain ALU opcodes -> pc 0,1,2,3,4; instr_valid=1; retired=4.
//  T2 pc=5, cu_Jump=01, jump_target=0x20 -> pc=0x20 next cycle.
//     cu_Jump=10, reg_target=0x3 -> pc=3.
//     cu_Jump=01 with cu_Branch=1, taken=1, branch_target=0x7 -> jump wins, pc=jump_target.
//  T3 pc=9, cu_inSignal=1, in_confirm held high on entry -> stays WAIT_IN with instr_valid=0.
//     Release then press -> one COMMIT_IN cycle with instr_valid=1, then pc=10, RUN.
//  T4 cu_hlt at pc=12, other cu_* driven X -> halted=1, pc stays 12 for 10 cycles.
//     resume pulse -> pc=13, RUN.
//  T5 cu_reset at pc=0x3FF with cu_Jump=X -> pc=0, retired=0.
//     Separately, pc=0x3FF with no flow change -> pc wraps to 0, link_addr=0 at pc=0x3FF.
//  T6 assert reset in WAIT_IN -> pc=0, RUN, waiting_in=0 immediately; no instr_valid pulse for the pending IN.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program counter sequencer that closes the fetch -> decode loop. It picks the
//   next instruction address from the control unit's flow signals, sequences
//   HALT, IN (wait for a user confirm press) and program reset, and qualifies
//   datapath side effects through instr_valid.
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   cu_Jump[1:0]          : 00 none, 01 absolute jump, 10 jump-to-register, 11 none
//   cu_Branch,
//   branch_taken          : conditional branch and its ALU outcome
//   cu_hlt, cu_reset,
//   cu_inSignal           : halt, program-reset and IN instructions
//   in_confirm, resume    : level inputs, rising edges detected internally
//   jump_target,
//   reg_target,
//   branch_target         : candidate next-pc values
//   pc, link_addr         : current address and pc+1 (wrapping) for link writes
//   instr_valid           : current instruction may commit side effects
//   halted, waiting_in    : state decode
//   retired               : saturating count of cycles with instr_valid=1
module pc_sequencer #(
  parameter int PC_W    = 10,
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         cu_Jump,
  input  logic               cu_Branch,
  input  logic               branch_taken,
  input  logic               cu_hlt,
  input  logic               cu_reset,
  input  logic               cu_inSignal,
  input  logic               in_confirm,
  input  logic               resume,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [PC_W-1:0]    reg_target,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    link_addr,
  output logic               instr_valid,
  output logic               halted,
  output logic               waiting_in,
  output logic [COUNT_W-1:0] retired
);

  localparam logic [1:0] ST_RUN       = 2'b00;
  localparam logic [1:0] ST_WAIT_IN   = 2'b01;
  localparam logic [1:0] ST_COMMIT_IN = 2'b10;
  localparam logic [1:0] ST_HALT      = 2'b11;

  localparam logic [COUNT_W-1:0] RETIRED_MAX = {COUNT_W{1'b1}};
  localparam logic [PC_W-1:0]    PC_ZERO     = {PC_W{1'b0}};
  localparam logic [PC_W-1:0]    PC_ONE      = {{(PC_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [PC_W-1:0]    pc_r;
  logic [PC_W-1:0]    pc_nxt_s;
  logic [PC_W-1:0]    pc_inc_s;
  logic [COUNT_W-1:0] retired_r;
  logic [COUNT_W-1:0] retired_nxt_s;
  logic               in_prev_r;
  logic               resume_prev_r;
  logic               in_edge_s;
  logic               resume_edge_s;
  logic               valid_s;
  logic               clear_retired_s;

  // Natural wrap of the adder gives pc+1 mod 2^PC_W for both pc and link_addr.
  assign pc_inc_s      = pc_r + PC_ONE;
  // Only a fresh press counts; a level already high on entry is ignored.
  assign in_edge_s     = in_confirm & ~in_prev_r;
  assign resume_edge_s = resume & ~resume_prev_r;

  // Commit qualifier; the IN instruction is suppressed combinationally so its
  // write happens only in the later COMMIT_IN cycle. Priority mirrors the
  // next-pc chain so that X on a lower-priority input cannot leak in.
  always_comb begin
    valid_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (cu_reset) begin
          valid_s = 1'b1;
        end else if (cu_hlt) begin
          valid_s = 1'b1;
        end else if (cu_inSignal) begin
          valid_s = 1'b0;
        end else begin
          valid_s = 1'b1;
        end
      end
      ST_COMMIT_IN: valid_s = 1'b1;
      default:      valid_s = 1'b0;
    endcase
  end

  // Next state / next pc selection.
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    clear_retired_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (cu_reset) begin
          pc_nxt_s        = PC_ZERO;
          clear_retired_s = 1'b1;
        end else if (cu_hlt) begin
          state_nxt_s = ST_HALT;
        end else if (cu_inSignal) begin
          state_nxt_s = ST_WAIT_IN;
        end else if (cu_Jump == 2'b01) begin
          pc_nxt_s = jump_target;
        end else if (cu_Jump == 2'b10) begin
          pc_nxt_s = reg_target;
        end else if (cu_Branch && branch_taken) begin
          pc_nxt_s = branch_target;
        end else begin
          pc_nxt_s = pc_inc_s;
        end
      end
      ST_WAIT_IN: begin
        if (in_edge_s) begin
          state_nxt_s = ST_COMMIT_IN;
        end else begin
          state_nxt_s = ST_WAIT_IN;
        end
      end
      ST_COMMIT_IN: begin
        pc_nxt_s    = pc_inc_s;
        state_nxt_s = ST_RUN;
      end
      ST_HALT: begin
        if (resume_edge_s) begin
          pc_nxt_s    = pc_inc_s;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        pc_nxt_s    = pc_r;
      end
    endcase
  end

  // Retired counter: program reset clears without counting its own cycle.
  always_comb begin
    if (clear_retired_s) begin
      retired_nxt_s = {COUNT_W{1'b0}};
    end else if (valid_s && (retired_r != RETIRED_MAX)) begin
      retired_nxt_s = retired_r + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_nxt_s = retired_r;
    end
  end

  // State, pc, counter and edge-detect registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_RUN;
      pc_r          <= PC_ZERO;
      retired_r     <= {COUNT_W{1'b0}};
      in_prev_r     <= 1'b0;
      resume_prev_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      retired_r     <= retired_nxt_s;
      in_prev_r     <= in_confirm;
      resume_prev_r <= resume;
    end
  end

  assign pc          = pc_r;
  assign link_addr   = pc_inc_s;
  assign instr_valid = valid_s;
  assign halted      = (state_r == ST_HALT);
  assign waiting_in  = (state_r == ST_WAIT_IN);
  assign retired     = retired_r;

endmodule
